// File: rtl/i2c_send_arbiter_if.sv
// i2c_send_arbiter_if
// Bundles the requester-side and engine-side signals of the I2C send arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the environment, which holds both the requesters and the i2cSend engine.
interface i2c_send_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]   req;
    logic [7*N_REQ-1:0] req_dev_addr;
    logic [8*N_REQ-1:0] req_inner_addr;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done_pulse;
    logic [N_REQ-1:0]   err_pulse;
    logic               busy;
    logic               eng_enable;
    logic [6:0]         eng_dev_addr;
    logic [7:0]         eng_inner_addr;
    logic [7:0]         eng_data;
    logic               eng_done;

    modport slave (
        input  req, req_dev_addr, req_inner_addr, req_data, eng_done,
        output grant, done_pulse, err_pulse, busy,
               eng_enable, eng_dev_addr, eng_inner_addr, eng_data
    );

    modport master (
        output req, req_dev_addr, req_inner_addr, req_data, eng_done,
        input  grant, done_pulse, err_pulse, busy,
               eng_enable, eng_dev_addr, eng_inner_addr, eng_data
    );
endinterface

// File: rtl/i2c_send_arbiter.sv
// i2c_send_arbiter
// Round-robin arbiter that shares one i2cSend write engine between N_REQ
// requesters. The winner's payload is latched and then frozen for the whole
// transaction. The engine enable is held through RUN. The winner gets a
// one-cycle done or error pulse in RELEASE.
// Optional feature: define I2C_ARB_TIMEOUT_EN to abort a hung engine after
// TIMEOUT_CYCLES cycles in RUN. Without the macro, RUN waits for eng_done
// indefinitely and err_pulse stays zero.
module i2c_send_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input logic                clk,
    input logic                rst,
    i2c_send_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             nextState_s;
    logic [PTR_W-1:0]   rrPtr_r;
    logic [PTR_W-1:0]   winIdx_r;
    logic [PTR_W-1:0]   selIdx_s;
    logic [PTR_W:0]     cand_s;
    logic               selValid_s;
    logic               finishDone_s;
    logic               finishErr_s;
    logic               timeoutHit_s;
    logic [N_REQ-1:0]   grant_r;
    logic [N_REQ-1:0]   donePulse_r;
    logic               busy_r;
    logic               engEnable_r;
    logic [6:0]         engDevAddr_r;
    logic [7:0]         engInnerAddr_r;
    logic [7:0]         engData_r;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [TCNT_W-1:0]  tcnt_r;
    logic [N_REQ-1:0]   errPulse_r;

    assign timeoutHit_s = (tcnt_r == TCNT_LAST);

    // RUN-cycle counter: cleared while entering RUN, counts up in RUN, saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_r <= {TCNT_W{1'b0}};
        end else if (state_r == GRANT) begin
            tcnt_r <= {TCNT_W{1'b0}};
        end else if (state_r == RUN && tcnt_r != {TCNT_W{1'b1}}) begin
            tcnt_r <= tcnt_r + {{(TCNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Error pulse to the winner on the cycle after a timeout abort
    always_ff @(posedge clk) begin
        if (rst) begin
            errPulse_r <= {N_REQ{1'b0}};
        end else begin
            errPulse_r <= finishErr_s ? grant_r : {N_REQ{1'b0}};
        end
    end

    assign bus.err_pulse = errPulse_r;
`else
    assign timeoutHit_s  = 1'b0;
    assign bus.err_pulse = {N_REQ{1'b0}};
`endif

    // Round-robin pick: first requester at or above rrPtr_r, wrapping around
    always_comb begin
        selValid_s = 1'b0;
        selIdx_s   = {PTR_W{1'b0}};
        cand_s     = {(PTR_W+1){1'b0}};
        for (int off = 0; off < N_REQ; off++) begin
            cand_s = {1'b0, rrPtr_r} + (PTR_W+1)'(off);
            if (cand_s >= (PTR_W+1)'(N_REQ)) begin
                cand_s = cand_s - (PTR_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!selValid_s && bus.req[cand_s[PTR_W-1:0]]) begin
                selValid_s = 1'b1;
                selIdx_s   = cand_s[PTR_W-1:0];
            end else begin
                selValid_s = selValid_s;
            end
        end
    end

    // Next-state logic. In RUN, eng_done takes priority over a simultaneous timeout.
    always_comb begin
        nextState_s  = state_r;
        finishDone_s = 1'b0;
        finishErr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (selValid_s) begin
                    nextState_s = GRANT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            GRANT: begin
                nextState_s = RUN;
            end
            RUN: begin
                if (bus.eng_done) begin
                    nextState_s  = RELEASE;
                    finishDone_s = 1'b1;
                end else if (timeoutHit_s) begin
                    nextState_s = RELEASE;
                    finishErr_s = 1'b1;
                end else begin
                    nextState_s = RUN;
                end
            end
            RELEASE: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Registered outputs, grant, payload latch and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r         <= 1'b0;
            engEnable_r    <= 1'b0;
            donePulse_r    <= {N_REQ{1'b0}};
            grant_r        <= {N_REQ{1'b0}};
            winIdx_r       <= {PTR_W{1'b0}};
            rrPtr_r        <= {PTR_W{1'b0}};
            engDevAddr_r   <= 7'd0;
            engInnerAddr_r <= 8'd0;
            engData_r      <= 8'd0;
        end else begin
            busy_r      <= (nextState_s != IDLE);
            engEnable_r <= (nextState_s == RUN);
            donePulse_r <= finishDone_s ? grant_r : {N_REQ{1'b0}};
            if (state_r == IDLE && selValid_s) begin
                grant_r        <= ONE_HOT0 << selIdx_s;
                winIdx_r       <= selIdx_s;
                engDevAddr_r   <= bus.req_dev_addr[int'(selIdx_s)*7 +: 7];
                engInnerAddr_r <= bus.req_inner_addr[int'(selIdx_s)*8 +: 8];
                engData_r      <= bus.req_data[int'(selIdx_s)*8 +: 8];
            end else if (state_r == RELEASE) begin
                grant_r <= {N_REQ{1'b0}};
                if (winIdx_r == PTR_W'(N_REQ - 1)) begin
                    rrPtr_r <= {PTR_W{1'b0}};
                end else begin
                    rrPtr_r <= winIdx_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign bus.grant          = grant_r;
    assign bus.done_pulse     = donePulse_r;
    assign bus.busy           = busy_r;
    assign bus.eng_enable     = engEnable_r;
    assign bus.eng_dev_addr   = engDevAddr_r;
    assign bus.eng_inner_addr = engInnerAddr_r;
    assign bus.eng_data       = engData_r;

endmodule

// File: tb/tb_i2c_send_arbiter.sv
// tb_i2c_send_arbiter
// Directed bench for i2c_send_arbiter. The stimulus pushes one expected
// completion per transaction into a queue. A negedge monitor checks the
// granted payload every cycle and pops and compares on each done/err pulse.
// A small engine model answers eng_done a programmable number of enable
// cycles after eng_enable rises. A delay of 0 models a hung engine.
module tb_i2c_send_arbiter;

    typedef struct {
        logic [3:0] grant;
        logic       isErr;
        logic [6:0] dev;
        logic [7:0] inner;
        logic [7:0] data;
        int         enCycles;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   engDelay = 0;
    int   engCnt = 0;
    int   enCnt = 0;
    exp_t expQ[$];

    i2c_send_arbiter_if #(.N_REQ(4)) bus ();

    i2c_send_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic setPayload(input int i, input logic [6:0] dev, input logic [7:0] inner,
                              input logic [7:0] data);
        bus.req_dev_addr[7*i +: 7]   = dev;
        bus.req_inner_addr[8*i +: 8] = inner;
        bus.req_data[8*i +: 8]       = data;
    endtask

    task automatic pushExp(input logic [3:0] g, input logic e, input logic [6:0] dev,
                           input logic [7:0] inner, input logic [7:0] data, input int en);
        exp_t x;
        x.grant = g; x.isErr = e; x.dev = dev; x.inner = inner; x.data = data; x.enCycles = en;
        expQ.push_back(x);
    endtask

    // Waits for n completion pulses; optionally checks the pulse-to-pulse period
    task automatic waitPulses(input int n, input int budget, input int period);
        int seen = 0;
        int cyc = 0;
        int last = -1;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (|bus.done_pulse || |bus.err_pulse) begin
                if (period > 0 && last >= 0) chk("pulse_period", cyc - last, period);
                last = cyc;
                seen++;
            end
        end
        if (seen < n) chk("pulse_wait_timeout", seen, n);
    endtask

    task automatic waitEnable(input int budget);
        int cyc = 0;
        while (!bus.eng_enable && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.eng_enable) chk("enable_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_done"}, bus.done_pulse, 0);
        chk({tag, "_err"}, bus.err_pulse, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_enable"}, bus.eng_enable, 0);
        chk({tag, "_dev"}, bus.eng_dev_addr, 0);
        chk({tag, "_inner"}, bus.eng_inner_addr, 0);
        chk({tag, "_data"}, bus.eng_data, 0);
    endtask

    // Engine model: raises eng_done during the engDelay-th enable cycle
    always @(negedge clk) begin
        if (rst || !bus.eng_enable) begin
            engCnt = 0;
            bus.eng_done = 1'b0;
        end else begin
            engCnt++;
            bus.eng_done = (engDelay > 0 && engCnt == engDelay);
        end
    end

    // Monitor: per-cycle payload freeze check and pulse scoreboard
    always @(negedge clk) begin
        if (rst) begin
            enCnt = 0;
        end else begin
            if (bus.eng_enable) enCnt++;
            if (bus.grant != 4'd0 && expQ.size() > 0) begin
                chk("mon_grant", bus.grant, expQ[0].grant);
                chk("mon_dev", bus.eng_dev_addr, expQ[0].dev);
                chk("mon_inner", bus.eng_inner_addr, expQ[0].inner);
                chk("mon_data", bus.eng_data, expQ[0].data);
            end
            if (|bus.done_pulse || |bus.err_pulse) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_pulse", {bus.done_pulse, bus.err_pulse}, 0);
                end else begin
                    exp_t x;
                    x = expQ.pop_front();
                    chk("done_pulse", bus.done_pulse, x.isErr ? 4'd0 : x.grant);
                    chk("err_pulse", bus.err_pulse, x.isErr ? x.grant : 4'd0);
                    chk("enable_cycles", enCnt, x.enCycles);
                    chk("enable_in_release", bus.eng_enable, 0);
                    chk("busy_in_release", bus.busy, 1);
                end
                enCnt = 0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.req = 4'd0;
        bus.req_dev_addr = '0;
        bus.req_inner_addr = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        // Single request with the 101-cycle engine
        @(negedge clk);
        setPayload(0, 7'h50, 8'h10, 8'hA5);
        engDelay = 101;
        pushExp(4'b0001, 1'b0, 7'h50, 8'h10, 8'hA5, 101);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("grant_after_req", bus.grant, 4'b0001);
        chk("busy_after_req", bus.busy, 1);
        chk("enable_in_grant", bus.eng_enable, 0);
        chk("payload_in_grant", {bus.eng_dev_addr, bus.eng_inner_addr, bus.eng_data},
            {7'h50, 8'h10, 8'hA5});
        @(negedge clk);
        chk("enable_rise", bus.eng_enable, 1);
        waitPulses(1, 300, 0);
        bus.req = 4'd0;
        @(negedge clk);
        chk("busy_after_done", bus.busy, 0);
        chk("grant_after_done", bus.grant, 0);
        chk("pulse_one_cycle", bus.done_pulse, 0);

        // Round-robin with all requesters held, starting from rr_ptr = 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) setPayload(i, 7'(7'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i));
        engDelay = 3;
        pushExp(4'b0001, 1'b0, 7'h10, 8'h20, 8'h30, 3);
        pushExp(4'b0010, 1'b0, 7'h11, 8'h21, 8'h31, 3);
        pushExp(4'b0100, 1'b0, 7'h12, 8'h22, 8'h32, 3);
        pushExp(4'b1000, 1'b0, 7'h13, 8'h23, 8'h33, 3);
        pushExp(4'b0001, 1'b0, 7'h10, 8'h20, 8'h30, 3);
        bus.req = 4'b1111;
        waitPulses(5, 100, 6);
        bus.req = 4'd0;

        // Request dropped mid-RUN; payload source changes but engine data stays
        @(negedge clk);
        setPayload(2, 7'h33, 8'h44, 8'h55);
        engDelay = 20;
        pushExp(4'b0100, 1'b0, 7'h33, 8'h44, 8'h55, 20);
        bus.req = 4'b0100;
        waitEnable(10);
        repeat (5) @(negedge clk);
        bus.req = 4'd0;
        bus.req_data[23:16] = 8'hFF;
        waitPulses(1, 50, 0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Hung engine: abort after exactly 50 RUN cycles
        @(negedge clk);
        setPayload(3, 7'h61, 8'h62, 8'h63);
        engDelay = 0;
        pushExp(4'b1000, 1'b1, 7'h61, 8'h62, 8'h63, 50);
        bus.req = 4'b1000;
        waitPulses(1, 100, 0);
        bus.req = 4'd0;
        // eng_done on the final RUN cycle beats the timeout
        @(negedge clk);
        setPayload(0, 7'h70, 8'h71, 8'h72);
        engDelay = 50;
        pushExp(4'b0001, 1'b0, 7'h70, 8'h71, 8'h72, 50);
        bus.req = 4'b0001;
        waitPulses(1, 100, 0);
        bus.req = 4'd0;
`endif

        // Move rr_ptr to 2 so the pre-reset winner of 0110 is requester 2
        @(negedge clk);
        engDelay = 3;
        pushExp(4'b0010, 1'b0, 7'h11, 8'h21, 8'h31, 3);
        bus.req = 4'b0010;
        waitPulses(1, 50, 0);
        bus.req = 4'd0;

        // Reset mid-RUN, then requester 1 must win first
        @(negedge clk);
        engDelay = 0;
        bus.req = 4'b0110;
        waitEnable(10);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("mid_run_reset");
        engDelay = 4;
        pushExp(4'b0010, 1'b0, 7'h11, 8'h21, 8'h31, 4);
        pushExp(4'b0100, 1'b0, 7'h33, 8'h44, 8'hFF, 4);
        rst = 1'b0;
        waitPulses(2, 50, 7);
        bus.req = 4'd0;

        repeat (4) @(negedge clk);
        chk("queue_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
